// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: state encodings, frame width
// and the baud divider formula shared with the transmitter.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, integer-truncated. Both link ends use this
  // so they derive identical bit timing from the same parameters.
  function automatic int calc_div(input int clock_freq, input int baud_rate,
                                  input int oversample);
    return clock_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks.
// restart_i clears the divider so the tick phase can be re-aligned to an edge.
module uart_baud_tick
  import uart_rx_pkg::*;
#(
  parameter int DIV = 54
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  // A zero divider means the clock is too slow for the requested baud rate.
  generate
    if (DIV < 1) begin : g_bad_div
      $error("uart_baud_tick: DIV must be at least 1");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;

  // Next divider count: wrap at the terminal count, clear on restart.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, with oversampled start-bit validation,
// mid-bit data sampling and stop-bit framing check.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | line idle, waiting for a falling edge on rx_s
// START      | validating the start bit at its half-bit point
// DATA       | sampling one data bit per bit period, LSB first
// STOP       | sampling the stop bit; good -> rx_valid, low -> frame_err
// WAIT_IDLE  | after a framing error, waiting for the line to return high
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUD_RATE  = 115200,
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       rx_busy_o
);

  localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam logic [SCW-1:0] SC_HALF  = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

  // Half-bit start validation needs an even tick count per bit.
  generate
    if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
      $error("uart_rx: OVERSAMPLE must be even and at least 8");
    end
  endgenerate

  logic                 rx_meta_q, rx_s_q;
  rx_state_e            state_q, state_d;
  logic [SCW-1:0]       sc_q, sc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 restart;
  logic                 tick;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state, counter, shift and output-pulse logic.
  always_comb begin
    state_d     = state_q;
    sc_d        = sc_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    restart     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          sc_d    = '0;
          restart = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (sc_q == SC_HALF) begin
            sc_d  = '0;
            bit_d = '0;
            // A line that is already high again was a glitch, not a start bit.
            state_d = rx_s_q ? ST_IDLE : ST_DATA;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (sc_q == SC_LAST) begin
            sc_d    = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (sc_q == SC_LAST) begin
            sc_d = '0;
            if (rx_s_q) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = ST_WAIT_IDLE;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // Hold here through a break so it is not mistaken for a new start bit.
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters, shift register and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      sc_q        <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sc_q        <= sc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;
  assign rx_busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a behavioural 8N1 transmitter drives rx_i, expected
// bytes / framing errors go into a queue, and a monitor pops on every pulse.
// Timing is scaled (100 MHz clock, 6.25 Mbaud, x8 oversample -> 16 clk/bit)
// so the run stays short.
module tb_uart_rx;

  localparam real BIT_NS = 160.0;

  logic       clk_i;
  logic       rst_ni;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       rx_busy_o;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  real        valid_times[$];
  logic [7:0] last_good;
  int         n_pass;
  int         n_total;

  uart_rx #(
    .BAUD_RATE  (6_250_000),
    .CLOCK_FREQ (100_000_000),
    .OVERSAMPLE (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .frame_err_o (frame_err_o),
    .rx_busy_o   (rx_busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_good(input logic [7:0] b);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = b;
    exp_q.push_back(e);
    last_good = b;
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = last_good;
    exp_q.push_back(e);
  endtask

  // Start bit plus data bits; leaves rx_i at the last data bit.
  task automatic send_bits(input logic [7:0] b, input int nbits, input real bit_ns);
    rx_i = 1'b0;
    #(bit_ns);
    for (int i = 0; i < nbits; i++) begin
      rx_i = b[i];
      #(bit_ns);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input real bit_ns);
    send_bits(b, 8, bit_ns);
    rx_i = 1'b1;
    #(bit_ns);
  endtask

  task automatic wait_busy(input logic lvl, input int max_clk, input string name);
    int n;
    n = 0;
    while ((rx_busy_o !== lvl) && (n < max_clk)) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 32'(rx_busy_o), 32'(lvl));
  endtask

  // Monitor: every output pulse consumes one expectation.
  always @(negedge clk_i) begin
    if (rst_ni && (rx_valid_o || frame_err_o)) begin
      if (rx_valid_o && frame_err_o) begin
        n_total++;
        $display("FAIL pulse_exclusive: rx_valid and frame_err both 1 at %0t", $time);
      end
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b data=%0h with nothing expected at %0t",
                 rx_valid_o, frame_err_o, rx_data_o, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind_err", 32'(frame_err_o), 32'(e.is_err));
        check("rx_data", 32'(rx_data_o), 32'(e.data));
      end
      if (rx_valid_o) valid_times.push_back($realtime);
    end
  end

  initial begin
    real diff;
    int  n;
    logic [7:0] b;
    n_pass    = 0;
    n_total   = 0;
    last_good = 8'h00;
    rx_i      = 1'b1;
    rst_ni    = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_rx_data", 32'(rx_data_o), 32'h00);
    check("reset_rx_valid", 32'(rx_valid_o), 32'h0);
    check("reset_frame_err", 32'(frame_err_o), 32'h0);
    check("reset_rx_busy", 32'(rx_busy_o), 32'h0);
    rst_ni = 1'b1;
    repeat (5) @(negedge clk_i);
    #2;

    // Basic byte.
    expect_good(8'h55);
    send_frame(8'h55, BIT_NS);
    #(BIT_NS);

    // Back-to-back frames with no idle gap.
    valid_times.delete();
    expect_good(8'hA5);
    send_frame(8'hA5, BIT_NS);
    expect_good(8'h3C);
    send_frame(8'h3C, BIT_NS);
    #(BIT_NS);
    check("b2b_count", 32'(valid_times.size()), 32'd2);
    if (valid_times.size() == 2) begin
      diff = valid_times[1] - valid_times[0];
      check("b2b_spacing_ok", 32'((diff >= 10.0 * BIT_NS - 20.0) && (diff <= 10.0 * BIT_NS + 20.0)), 32'd1);
    end

    // Short glitch in idle: busy rises then falls, no pulse.
    rx_i = 1'b0;
    #40;
    rx_i = 1'b1;
    wait_busy(1'b1, 10, "glitch_busy_high");
    wait_busy(1'b0, 40, "glitch_busy_low");
    check("glitch_data_kept", 32'(rx_data_o), 32'h3C);
    #(2.0 * BIT_NS);

    // Framing error with the line held low past the stop bit.
    expect_err();
    send_bits(8'hF0, 8, BIT_NS);
    rx_i = 1'b0;
    #370;
    check("break_busy_held", 32'(rx_busy_o), 32'h1);
    check("break_data_kept", 32'(rx_data_o), 32'h3C);
    rx_i = 1'b1;
    wait_busy(1'b0, 20, "break_busy_released");
    #(BIT_NS);
    expect_good(8'h81);
    send_frame(8'h81, BIT_NS);
    #(BIT_NS);

    // Reset in the middle of data bit 4.
    send_bits(8'h0F, 4, BIT_NS);
    rx_i = 1'b0;
    #(BIT_NS / 2.0);
    rst_ni = 1'b0;
    #2;
    check("midrst_rx_data", 32'(rx_data_o), 32'h00);
    check("midrst_rx_valid", 32'(rx_valid_o), 32'h0);
    check("midrst_frame_err", 32'(frame_err_o), 32'h0);
    check("midrst_rx_busy", 32'(rx_busy_o), 32'h0);
    rx_i = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    #(BIT_NS);
    expect_good(8'h0F);
    send_frame(8'h0F, BIT_NS);
    #(BIT_NS);

    // Loopback-style stream at nominal rate, then with +/-2% skew.
    expect_good(8'h00);
    send_frame(8'h00, BIT_NS);
    expect_good(8'hFF);
    send_frame(8'hFF, BIT_NS);
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      expect_good(b);
      send_frame(b, BIT_NS);
    end
    #(2.0 * BIT_NS);
    for (int s = 0; s < 2; s++) begin
      real skew_ns;
      skew_ns = (s == 0) ? BIT_NS * 1.02 : BIT_NS * 0.98;
      expect_good(8'h00);
      send_frame(8'h00, skew_ns);
      expect_good(8'hFF);
      send_frame(8'hFF, skew_ns);
      for (int i = 0; i < 32; i++) begin
        b = 8'($urandom_range(0, 255));
        expect_good(b);
        send_frame(b, skew_ns);
      end
      #(2.0 * BIT_NS);
    end

    n = 0;
    while ((exp_q.size() != 0) && (n < 500)) begin
      @(negedge clk_i);
      n++;
    end
    check("all_expected_received", 32'(exp_q.size()), 32'd0);
    check("final_idle", 32'(rx_busy_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
